// File: rtl/i2s_pkg.sv
// i2s_pkg
// Shared definitions for the I2S transmit sequencer: FSM state encodings,
// default sample width and bit-clock divide ratio, and the frame length
// (one left plus one right sample).
// No ports.

package i2s_pkg;

  // Sequencer states. Plain constants keep the encoding stable for
  // older tools and for anything that peeks at the state register.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int DEF_SAMPLE_W  = 16;
  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_FRAME_LEN = 2 * DEF_SAMPLE_W;

  // Bits per stereo frame for an arbitrary sample width.
  function automatic int frame_len(input int sample_w);
    return 2 * sample_w;
  endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// i2s_sck_gen
// Bit-clock divider. While run is high, SCK toggles every CLK_DIV fpga_clk
// cycles. The strobes are high during the cycle whose closing rising edge
// performs the corresponding SCK transition. Dropping run parks SCK low and
// restarts the divider, so the next run begins with a full low half-period.
// Ports:
//   fpga_clk  - system clock
//   nrst      - synchronous active-low reset
//   run       - divider enable
//   sck       - bit clock
//   sck_rise  - next edge takes SCK 0->1
//   sck_fall  - next edge takes SCK 1->0

module i2s_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic fpga_clk,
  input  logic nrst,
  input  logic run,
  output logic sck,
  output logic sck_rise,
  output logic sck_fall
);

  localparam int DIV_W = 8;

  logic [DIV_W-1:0] div_cnt;
  logic             div_done;

  assign div_done = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign sck_rise = run && div_done && !sck;
  assign sck_fall = run && div_done && sck;

  always_ff @(posedge fpga_clk) begin
    if (!nrst) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (div_done) begin
      div_cnt <= '0;
      sck     <= !sck;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/i2s_tx_sequencer.sv
// i2s_tx_sequencer
// Stereo I2S transmitter. A one-entry holding register accepts sample pairs
// over a valid/ready handshake; the serializer loads a full frame
// {left, right} from it and shifts it out MSB first, one bit per SCK period.
// If the holding register is empty at a frame boundary a silent frame is
// sent and underrun pulses. Dropping enable lets the current frame finish
// before going idle.
// Ports:
//   fpga_clk, nrst            - clock, synchronous active-low reset
//   enable                    - request streaming
//   s_valid/s_ready           - sample pair handshake
//   s_left/s_right            - two's complement samples
//   I2S_clk_out               - SCK
//   I2S_word_select           - WS (0 = left, 1 = right)
//   I2S_data_out              - SD
//   frame_start               - one-cycle pulse after every frame load
//   underrun                  - one-cycle pulse after a silent-frame load

module i2s_tx_sequencer
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int CLK_DIV  = DEF_CLK_DIV
) (
  input  logic                fpga_clk,
  input  logic                nrst,
  input  logic                enable,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                I2S_clk_out,
  output logic                I2S_word_select,
  output logic                I2S_data_out,
  output logic                frame_start,
  output logic                underrun
);

  localparam int FRAME_LEN = frame_len(SAMPLE_W);
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

  logic [1:0]            state;
  logic [SAMPLE_W-1:0]   hold_l;
  logic [SAMPLE_W-1:0]   hold_r;
  logic                  hold_full;
  logic [FRAME_LEN-1:0]  shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      next_bit;
  logic                  wrap_armed;
  logic                  sck_rise;
  logic                  sck_fall;
  logic                  frame_wrap;
  logic                  load_frame;
  logic                  load_empty;
  logic                  stop_frame;

  i2s_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .fpga_clk (fpga_clk),
    .nrst     (nrst),
    .run      (state != ST_IDLE),
    .sck      (I2S_clk_out),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  assign s_ready      = !hold_full;
  assign I2S_data_out = shreg[FRAME_LEN-1];

  // WS looks one bit ahead so it changes one SCK before each channel MSB.
  assign next_bit        = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);
  assign I2S_word_select = (state != ST_IDLE) && (next_bit >= CNT_W'(SAMPLE_W));

  // The last-bit compare is registered on the SCK rise so the frame-wrap
  // decision at the following fall only has to AND two flops.
  always_ff @(posedge fpga_clk) begin
    if (!nrst) begin
      wrap_armed <= 1'b0;
    end else if (sck_fall) begin
      wrap_armed <= 1'b0;
    end else if (sck_rise) begin
      wrap_armed <= (bit_cnt == LAST_BIT);
    end
  end

  assign frame_wrap = sck_fall && wrap_armed;

  // Frame boundary decisions. A wrap with enable low ends streaming, which
  // covers both DRAIN and enable dropping exactly at the boundary.
  always_comb begin
    load_frame = 1'b0;
    load_empty = 1'b0;
    stop_frame = 1'b0;
    if (state == ST_IDLE) begin
      load_frame = enable && hold_full;
    end else if (frame_wrap) begin
      if (enable) begin
        load_frame = 1'b1;
        load_empty = !hold_full;
      end else begin
        stop_frame = 1'b1;
      end
    end
  end

  always_ff @(posedge fpga_clk) begin
    if (!nrst) begin
      state <= ST_IDLE;
    end else if (load_frame) begin
      state <= ST_RUN;
    end else if (stop_frame) begin
      state <= ST_IDLE;
    end else if (state == ST_RUN && !enable) begin
      state <= ST_DRAIN;
    end else if (state == ST_DRAIN && enable) begin
      state <= ST_RUN;
    end
  end

  // Serializer: shift on every SCK fall; loads and stops happen on the
  // wrap fall instead of a shift.
  always_ff @(posedge fpga_clk) begin
    if (!nrst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load_frame) begin
      shreg   <= load_empty ? '0 : {hold_l, hold_r};
      bit_cnt <= '0;
    end else if (stop_frame) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (sck_fall) begin
      shreg   <= shreg << 1;
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // Holding register. An accept can only coincide with a silent-frame load
  // (the register is empty), so a pair arriving then waits for the next frame.
  always_ff @(posedge fpga_clk) begin
    if (!nrst) begin
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
    end else begin
      if (load_frame && !load_empty) begin
        hold_full <= 1'b0;
      end
      if (s_valid && s_ready) begin
        hold_l    <= s_left;
        hold_r    <= s_right;
        hold_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge fpga_clk) begin
    if (!nrst) begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= load_frame;
      underrun    <= load_empty;
    end
  end

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// tb_i2s_tx_sequencer
// Directed bench for i2s_tx_sequencer with SAMPLE_W=16, CLK_DIV=2.
// One bit lasts 4 clocks (SCK low for 2, high for 2); a frame lasts 128.

module tb_i2s_tx_sequencer;
  import i2s_pkg::*;

  localparam int SW         = 16;
  localparam int CD         = 2;
  localparam int FRAME_CLKS = 2 * SW * 2 * CD;
  localparam logic [31:0] WS_PATTERN = 32'h7FFF_8000;

  logic          fpga_clk = 1'b0;
  logic          nrst     = 1'b0;
  logic          enable   = 1'b0;
  logic          s_valid  = 1'b0;
  logic          s_ready;
  logic [SW-1:0] s_left   = '0;
  logic [SW-1:0] s_right  = '0;
  logic          I2S_clk_out;
  logic          I2S_word_select;
  logic          I2S_data_out;
  logic          frame_start;
  logic          underrun;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] feed_q[$];
  logic [31:0] pairs[4] = '{32'h1111_EEEE, 32'h8001_7FFE, 32'hFFFF_0000, 32'h0000_FFFF};

  i2s_tx_sequencer #(
    .SAMPLE_W (SW),
    .CLK_DIV  (CD)
  ) dut (
    .fpga_clk        (fpga_clk),
    .nrst            (nrst),
    .enable          (enable),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_left          (s_left),
    .s_right         (s_right),
    .I2S_clk_out     (I2S_clk_out),
    .I2S_word_select (I2S_word_select),
    .I2S_data_out    (I2S_data_out),
    .frame_start     (frame_start),
    .underrun        (underrun)
  );

  always #5 fpga_clk = ~fpga_clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: offer the head of the feed queue, advance past the rising
  // edge, and retire the pair if the handshake completed on that edge.
  task automatic apply_stimulus();
    logic rdy;
    if (feed_q.size() > 0) begin
      s_valid = 1'b1;
      {s_left, s_right} = feed_q[0];
    end else begin
      s_valid = 1'b0;
    end
    rdy = s_ready;
    @(posedge fpga_clk);
    #1;
    if (s_valid && rdy) void'(feed_q.pop_front());
  endtask

  task automatic check_start(input string tag, input logic exp_ur);
    check_output({tag, "_fs"}, 32'(frame_start), 32'd1);
    check_output({tag, "_ur"}, 32'(underrun), 32'(exp_ur));
  endtask

  // Called right after a load edge; walks the whole frame and leaves the
  // bench right after the next frame-boundary edge.
  task automatic run_frame(input string tag, input logic [31:0] exp_sd, input int drop_bit,
                           input int raise_bit, input logic push_end, input logic [31:0] push_pair);
    logic [31:0] sd_w;
    logic [31:0] ws_w;
    int sck_bad;
    int fs_cnt;
    int ur_cnt;
    sd_w = '0;
    ws_w = '0;
    sck_bad = 0;
    fs_cnt = 0;
    ur_cnt = 0;
    for (int n = 0; n < FRAME_CLKS; n++) begin
      if (n % 4 == 0) begin
        sd_w = {sd_w[30:0], I2S_data_out};
        ws_w[n / 4] = I2S_word_select;
      end
      if (I2S_clk_out !== ((n % 4) >= 2)) sck_bad++;
      if (n > 0 && frame_start) fs_cnt++;
      if (n > 0 && underrun) ur_cnt++;
      if (n == 4 * drop_bit) enable = 1'b0;
      if (n == 4 * raise_bit) enable = 1'b1;
      if (push_end && n == FRAME_CLKS - 1) feed_q.push_back(push_pair);
      apply_stimulus();
    end
    check_output({tag, "_sd"}, sd_w, exp_sd);
    check_output({tag, "_ws"}, ws_w, WS_PATTERN);
    check_output({tag, "_sck"}, 32'(sck_bad), 32'd0);
    check_output({tag, "_fs_mid"}, 32'(fs_cnt), 32'd0);
    check_output({tag, "_ur_mid"}, 32'(ur_cnt), 32'd0);
  endtask

  initial begin
    int quiet;

    // Reset state
    nrst = 1'b0;
    repeat (2) apply_stimulus();
    check_output("rst_sck", 32'(I2S_clk_out), 32'd0);
    check_output("rst_ws", 32'(I2S_word_select), 32'd0);
    check_output("rst_sd", 32'(I2S_data_out), 32'd0);
    check_output("rst_ready", 32'(s_ready), 32'd1);
    check_output("rst_fs", 32'(frame_start), 32'd0);
    check_output("rst_ur", 32'(underrun), 32'd0);

    // Single pair accepted while disabled, then enable
    nrst = 1'b1;
    feed_q.push_back({16'hA5A5, 16'h1234});
    apply_stimulus();
    check_output("held_ready", 32'(s_ready), 32'd0);
    repeat (3) apply_stimulus();
    check_output("idle_sck", 32'(I2S_clk_out), 32'd0);
    check_output("idle_fs", 32'(frame_start), 32'd0);
    enable = 1'b1;
    apply_stimulus();
    check_start("a_start", 1'b0);
    check_output("a_ready", 32'(s_ready), 32'd1);
    run_frame("frame_a", 32'hA5A5_1234, -1, -1, 1'b0, 32'd0);

    // Starvation, with a pair arriving exactly on the next silent-frame load
    check_start("b_start", 1'b1);
    run_frame("frame_b", 32'd0, -1, -1, 1'b1, {16'h0F0F, 16'hC3C3});
    check_start("c_start", 1'b1);
    check_output("c_ready", 32'(s_ready), 32'd0);
    run_frame("frame_c", 32'd0, -1, -1, 1'b0, 32'd0);

    // Late pair plays here; enable drops at bit 10 and the frame completes
    check_start("d_start", 1'b0);
    run_frame("frame_d", 32'h0F0F_C3C3, 10, -1, 1'b0, 32'd0);
    check_output("stop_fs", 32'(frame_start), 32'd0);
    check_output("stop_ur", 32'(underrun), 32'd0);
    check_output("stop_state", 32'(dut.state), 32'(ST_IDLE));
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      if (I2S_clk_out || I2S_word_select || I2S_data_out || frame_start) quiet++;
      apply_stimulus();
    end
    check_output("stop_quiet", 32'(quiet), 32'd0);

    // Enabled with an empty holding register: stays idle, no underrun
    enable = 1'b1;
    quiet = 0;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus();
      if (frame_start || underrun || I2S_clk_out) quiet++;
    end
    check_output("empty_idle", 32'(quiet), 32'd0);

    // Continuous stream of four pairs
    for (int i = 0; i < 4; i++) feed_q.push_back(pairs[i]);
    apply_stimulus();
    check_output("cont_wait_fs", 32'(frame_start), 32'd0);
    apply_stimulus();
    for (int f = 0; f < 4; f++) begin
      check_start($sformatf("cont%0d_start", f), 1'b0);
      run_frame($sformatf("cont%0d", f), pairs[f], -1, -1, 1'b0, 32'd0);
    end
    check_start("e_start", 1'b1);

    // Reset at bit 20 of a frame, with the holding register full
    feed_q.push_back(32'h7777_8888);
    repeat (80) apply_stimulus();
    check_output("pre_rst_ready", 32'(s_ready), 32'd0);
    nrst = 1'b0;
    apply_stimulus();
    check_output("mid_rst_sck", 32'(I2S_clk_out), 32'd0);
    check_output("mid_rst_ws", 32'(I2S_word_select), 32'd0);
    check_output("mid_rst_sd", 32'(I2S_data_out), 32'd0);
    check_output("mid_rst_ready", 32'(s_ready), 32'd1);
    check_output("mid_rst_fs", 32'(frame_start), 32'd0);
    check_output("mid_rst_ur", 32'(underrun), 32'd0);
    check_output("mid_rst_state", 32'(dut.state), 32'(ST_IDLE));
    nrst = 1'b1;
    quiet = 0;
    for (int i = 0; i < 12; i++) begin
      apply_stimulus();
      if (frame_start || underrun || I2S_clk_out || I2S_data_out) quiet++;
    end
    check_output("post_rst_quiet", 32'(quiet), 32'd0);

    // Enable dropped then reasserted during the drain: no frame gap
    feed_q.push_back(32'h5A5A_C001);
    repeat (2) apply_stimulus();
    check_start("g_start", 1'b0);
    run_frame("frame_g", 32'h5A5A_C001, 5, 12, 1'b0, 32'd0);
    check_start("g_next", 1'b1);

    enable = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2s_tx_sequencer.md
I2S_TX_SEQUENCER -- requirements
Module: i2s_tx_sequencer

Interface
REQ-001 Parameter SAMPLE_W, default 16, is the bit width of each channel sample.
REQ-002 Parameter CLK_DIV, default 2, is the number of fpga_clk cycles per I2S_clk_out half-period; legal values are 1 to 255.
REQ-003 Port fpga_clk, input, 1 bit, is the single system clock; all logic is clocked on its rising edge.
REQ-004 Port nrst, input, 1 bit, is the reset: synchronous and active-low.
REQ-005 Port enable, input, 1 bit, requests streaming.
REQ-006 Port s_valid, input, 1 bit, means a stereo sample pair is offered.
REQ-007 Port s_ready, output, 1 bit, means the block can accept a pair.
REQ-008 Port s_left, input, SAMPLE_W bits, is the left sample in two's complement, MSB first on the wire.
REQ-009 Port s_right, input, SAMPLE_W bits, is the right sample.
REQ-010 Port I2S_clk_out, output, 1 bit, is the serial bit clock (SCK).
REQ-011 Port I2S_word_select, output, 1 bit, is WS: 0 = left, 1 = right.
REQ-012 Port I2S_data_out, output, 1 bit, is serial data (SD).
REQ-013 Port frame_start, output, 1 bit, is a one-cycle pulse when a frame is loaded.
REQ-014 Port underrun, output, 1 bit, is a one-cycle pulse when a frame is loaded with no pair available.

Function
REQ-015 A one-entry holding register (hold_l, hold_r, hold_full) SHALL sit in front of the serializer.
REQ-016 s_ready SHALL equal !hold_full; a transfer happens when s_valid && s_ready on a rising edge, setting hold_full the next cycle.
REQ-017 States: IDLE, RUN, DRAIN.
REQ-018 IDLE -> RUN when enable && hold_full; with enable=1 and hold empty, the block stays in IDLE and no underrun is signalled.
REQ-019 The load cycle on entering RUN:
- shift register <= {hold_l, hold_r}; hold_full cleared; bit_cnt <= 0; SCK <= 0; frame_start pulses.
- The first SD bit (left MSB) is valid in the cycle after the load edge.
REQ-020 In RUN, SCK SHALL toggle every CLK_DIV cycles, giving an SCK period of 2*CLK_DIV cycles with 50% duty.
REQ-021 On each SCK falling edge (the SCK 1->0 register update):
- the shift register shifts left by 1;
- bit_cnt increments, modulo 2*SAMPLE_W.
REQ-022 SD SHALL always equal the shift register MSB, so SD changes only with SCK falling.
REQ-023 For frame bit k, WS SHALL be 1 iff ((k+1) mod 2*SAMPLE_W) >= SAMPLE_W; WS therefore leads the MSB of each channel by one SCK (standard I2S).
REQ-024 At the falling edge where bit_cnt wraps from 2*SAMPLE_W-1 to 0:
- if hold_full: load from hold, clear hold_full, pulse frame_start;
- else: load all zeros and pulse both frame_start and underrun.
REQ-025 A transfer accepted in the same cycle as a frame load SHALL fill the holding register after that load; it SHALL NOT be used by that frame.
REQ-026 enable falling during RUN SHALL move the block to DRAIN, which finishes the current frame.
REQ-027 At the DRAIN frame wrap the block SHALL go to IDLE with SCK=0, WS=0, SD=0 and no new load; hold contents are retained.
REQ-028 enable reasserted during DRAIN SHALL return the block to RUN with no frame gap.

Reset
REQ-029 When nrst=0 at a rising edge, the next state SHALL be:
- state=IDLE; hold_full=0; shift register=0; bit_cnt=0; divider=0;
- I2S_clk_out=0, I2S_word_select=0, I2S_data_out=0, s_ready=1, frame_start=0, underrun=0.
REQ-030 Reset SHALL override every other event, including mid-frame; no partial frame completes afterward.

Structure
REQ-031 Shared package i2s_pkg SHALL hold:
- the state enumeration (IDLE, RUN, DRAIN);
- the SAMPLE_W and CLK_DIV defaults;
- the frame-length constant 2*SAMPLE_W.
REQ-032 Sub-module i2s_sck_gen (divider producing SCK plus rise and fall strobes, with run input) SHALL be instantiated once; all other logic stays in i2s_tx_sequencer.

Verification (SAMPLE_W=16, CLK_DIV=2)
REQ-033 Single pair then enable: pair L=0xA5A5, R=0x1234 -> SD stream over 32 SCK periods (128 clocks) equals A5A5 then 1234 MSB-first; WS rises at bit 15 and falls at bit 31.
REQ-034 Continuous stream: s_valid held high with 4 pairs -> 4 back-to-back frames, frame_start every 128 clocks, underrun never pulses.
REQ-035 Starvation: one pair supplied, enable held -> second frame SD all 0 and one underrun pulse at clock 128 after the first load.
REQ-036 Disable mid-frame: enable dropped at bit 10 -> frame completes through bit 31, then SCK, WS and SD stay 0 and state is IDLE.
REQ-037 Reset at bit 20 of a frame -> next cycle all outputs match REQ-029 and s_ready=1.
REQ-038 Simultaneous transfer and frame-wrap load -> the new pair appears in the following frame, not the current one.
